// File: rtl/switch_debouncer_pkg.sv
// Shared defaults for the switch input-conditioning stage.
// The MCU runs at 50 MHz; the prescaler default gives one sample tick per millisecond.
package switch_debouncer_pkg;

    localparam int unsigned CLK_HZ           = 50_000_000;
    localparam int unsigned NUM_SW_DEF       = 16;
    localparam int unsigned TICK_DIV_DEF     = CLK_HZ / 1000;
    localparam int unsigned STABLE_TICKS_DEF = 8;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One switch bit: 2-flop synchronizer, tick-qualified mismatch counter,
// accepted level and registered rise/fall pulses.
module debounce_cell
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
    parameter logic        RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int unsigned    CW   = cnt_width(STABLE_TICKS + 1);
    localparam logic [CW-1:0]  LAST = CW'(STABLE_TICKS - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= RESET_VAL;
            sync   <= RESET_VAL;
            stable <= RESET_VAL;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            rise <= 1'b0;
            fall <= 1'b0;
            // Any cycle of agreement restarts qualification, so a bounce back costs the run.
            if (sync == stable) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == LAST) begin
                    stable <= sync;
                    cnt    <= '0;
                    rise   <= sync;
                    fall   <= ~sync;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Synchronizes and debounces the board slide switches for the MCU switch port,
// with a shared sample-tick prescaler and a sticky change interrupt.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned       NUM_SW       = NUM_SW_DEF,
    parameter int unsigned       TICK_DIV     = TICK_DIV_DEF,
    parameter int unsigned       STABLE_TICKS = STABLE_TICKS_DEF,
    parameter logic [NUM_SW-1:0] RESET_VAL    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_SW-1:0] sw_raw_i,
    output logic [NUM_SW-1:0] sw_stable_o,
    output logic [NUM_SW-1:0] sw_rise_o,
    output logic [NUM_SW-1:0] sw_fall_o,
    output logic              irq_o,
    input  logic              irq_clr_i
);

    localparam int unsigned   PW    = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt;
    logic          tick;

    assign tick = (pcnt == PLAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
        debounce_cell #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_VAL    (RESET_VAL[i])
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (sw_raw_i[i]),
            .tick   (tick),
            .stable (sw_stable_o[i]),
            .rise   (sw_rise_o[i]),
            .fall   (sw_fall_o[i])
        );
    end

    // A new edge outranks a simultaneous clear so no change is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_o <= 1'b0;
        end else if ((|sw_rise_o) || (|sw_fall_o)) begin
            irq_o <= 1'b1;
        end else if (irq_clr_i) begin
            irq_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: two configurations share stimulus and are compared every
// cycle against a run-length reference model, plus directed latency/pulse/irq checks.
module tb_switch_debouncer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw_raw;
    logic        irq_clr;
    logic [15:0] a_stable, a_rise, a_fall, b_stable, b_rise, b_fall;
    logic        a_irq, b_irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    switch_debouncer #(
        .NUM_SW(16), .TICK_DIV(4), .STABLE_TICKS(3), .RESET_VAL(16'h0000)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .sw_raw_i(sw_raw), .sw_stable_o(a_stable),
        .sw_rise_o(a_rise), .sw_fall_o(a_fall), .irq_o(a_irq), .irq_clr_i(irq_clr)
    );

    switch_debouncer #(
        .NUM_SW(16), .TICK_DIV(1), .STABLE_TICKS(1), .RESET_VAL(16'h0000)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .sw_raw_i(sw_raw), .sw_stable_o(b_stable),
        .sw_rise_o(b_rise), .sw_fall_o(b_fall), .irq_o(b_irq), .irq_clr_i(irq_clr)
    );

    // Reference: a new level is accepted on the tick that completes STABLE_TICKS ticks
    // inside an unbroken run of disagreement; ticks are counted arithmetically from the
    // edge index since reset release.
    int unsigned m_e      [2];
    int unsigned m_start  [2][16];
    logic [15:0] m_s1     [2];
    logic [15:0] m_s2     [2];
    logic [15:0] m_stable [2];
    logic [15:0] m_rise   [2];
    logic [15:0] m_fall   [2];
    logic [15:0] m_inrun  [2];
    logic        m_irq    [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_e[c] = 0;
            m_s1[c] = '0; m_s2[c] = '0; m_stable[c] = '0;
            m_rise[c] = '0; m_fall[c] = '0; m_inrun[c] = '0; m_irq[c] = 1'b0;
            for (int b = 0; b < 16; b++) m_start[c][b] = 0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        for (int c = 0; c < 2; c++) begin
            int unsigned td = (c == 0) ? 4 : 1;
            int unsigned st = (c == 0) ? 3 : 1;
            logic        tk = ((m_e[c] % td) == td - 1);
            logic        any = (|m_rise[c]) || (|m_fall[c]);
            logic [15:0] nr = '0;
            logic [15:0] nf = '0;
            for (int b = 0; b < 16; b++) begin
                if (m_s2[c][b] != m_stable[c][b]) begin
                    if (!m_inrun[c][b]) begin
                        m_inrun[c][b] = 1'b1;
                        m_start[c][b] = m_e[c];
                    end
                    if (tk && ((m_e[c] + 1) / td - m_start[c][b] / td) == st) begin
                        m_stable[c][b] = m_s2[c][b];
                        nr[b] = m_s2[c][b];
                        nf[b] = ~m_s2[c][b];
                        m_inrun[c][b] = 1'b0;
                    end
                end else begin
                    m_inrun[c][b] = 1'b0;
                end
            end
            m_rise[c] = nr;
            m_fall[c] = nf;
            m_irq[c]  = any ? 1'b1 : (irq_clr ? 1'b0 : m_irq[c]);
            m_s2[c]   = m_s1[c];
            m_s1[c]   = sw_raw;
            m_e[c]++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("a_stable", a_stable, m_stable[0]);
        chk("a_rise", a_rise, m_rise[0]);
        chk("a_fall", a_fall, m_fall[0]);
        chk("a_irq", a_irq, m_irq[0]);
        chk("b_stable", b_stable, m_stable[1]);
        chk("b_rise", b_rise, m_rise[1]);
        chk("b_fall", b_fall, m_fall[1]);
        chk("b_irq", b_irq, m_irq[1]);
    endtask

    // Edges until dut_a bit reaches val; limit+1 when it never does.
    task automatic wait_a(input int bit_i, input logic val, input int limit, output int lat);
        lat = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            cycle();
            if (a_stable[bit_i] === val) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_rises_a(input int bit_i, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (a_rise[bit_i] === 1'b1) cnt++;
        end
    endtask

    int lat;
    int cnt;

    initial begin
        rst_n   = 1'b0;
        sw_raw  = '0;
        irq_clr = 1'b0;
        model_reset();
        #1;
        chk("reset_stable", a_stable, 16'h0000);
        chk("reset_irq", a_irq, 1'b0);
        repeat (3) cycle();
        rst_n = 1'b1;

        // Clean step on bit 0
        sw_raw[0] = 1'b1;
        wait_a(0, 1'b1, 30, lat);
        chk("s1_latency_11_14", (lat >= 11 && lat <= 14), 1'b1);
        chk("s1_rise_with_level", a_rise[0], 1'b1);
        chk("s1_irq_not_yet", a_irq, 1'b0);
        cycle();
        chk("s1_rise_one_cycle", a_rise[0], 1'b0);
        chk("s1_irq_set", a_irq, 1'b1);

        // Bounce on bit 3, then hold high
        for (int seg = 0; seg < 12; seg++) begin
            sw_raw[3] = (seg % 2 == 0);
            for (int k = 0; k < 5; k++) begin
                cycle();
                chk("s2_hold_during_bounce", a_stable[3], 1'b0);
                chk("s2_no_rise_during_bounce", a_rise[3], 1'b0);
            end
        end
        sw_raw[3] = 1'b1;
        wait_a(3, 1'b1, 20, lat);
        chk("s2_latency_le_14", (lat <= 14), 1'b1);
        chk("s2_rise_pulse", a_rise[3], 1'b1);
        count_rises_a(3, 20, cnt);
        chk("s2_single_rise", cnt, 0);

        // Simultaneous edges with a clear colliding with the irq set
        sw_raw[2] = 1'b1;
        wait_a(2, 1'b1, 20, lat);
        cycle();
        cycle();
        irq_clr = 1'b1;
        cycle();
        irq_clr = 1'b0;
        chk("s3_irq_cleared", a_irq, 1'b0);
        sw_raw[5] = 1'b1;
        sw_raw[9] = 1'b1;
        sw_raw[2] = 1'b0;
        wait_a(5, 1'b1, 20, lat);
        chk("s3_rise_5_9", a_rise, 16'h0220);
        chk("s3_fall_2", a_fall, 16'h0004);
        chk("s3_stable_vec", a_stable & 16'h0224, 16'h0220);
        irq_clr = 1'b1;
        cycle();
        irq_clr = 1'b0;
        chk("s3_set_wins", a_irq, 1'b1);
        cycle();
        irq_clr = 1'b1;
        cycle();
        irq_clr = 1'b0;
        chk("s3_later_clear", a_irq, 1'b0);

        // Minimum config: exactly three edges
        cycle();
        sw_raw[10] = 1'b1;
        cycle();
        chk("s4_edge1", b_stable[10], 1'b0);
        cycle();
        chk("s4_edge2", b_stable[10], 1'b0);
        cycle();
        chk("s4_edge3", b_stable[10], 1'b1);
        chk("s4_rise", b_rise[10], 1'b1);

        // Reset in the middle of qualification
        repeat (20) cycle();
        sw_raw[7] = 1'b1;
        repeat (8) cycle();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("s5_async_stable", a_stable, 16'h0000);
        chk("s5_async_rise", a_rise, 16'h0000);
        chk("s5_async_irq", a_irq, 1'b0);
        chk("s5_async_b_stable", b_stable, 16'h0000);
        cycle();
        cycle();
        rst_n = 1'b1;
        wait_a(7, 1'b1, 30, lat);
        chk("s5_requalify_11_14", (lat >= 11 && lat <= 14), 1'b1);
        chk("s5_rise_pulse", a_rise[7], 1'b1);
        count_rises_a(7, 20, cnt);
        chk("s5_single_rise", cnt, 0);

        // Random stimulus against the model
        for (int n = 0; n < 800; n++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 24) == 0) sw_raw[b] = ~sw_raw[b];
            end
            irq_clr = ($urandom_range(0, 7) == 0);
            cycle();
        end
        irq_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
